// File: rtl/agc_pkg.sv
// Shared types and default constants for the AGC power controller.
// Holds the FSM state enum, compare-result enum and parameter defaults.
package agc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    SETTLE,
    DISCARD
  } agc_state_t;

  typedef enum logic [2:0] {
    HIGH_COARSE,
    HIGH,
    IN_WIN,
    LOW,
    LOW_COARSE
  } cmp_res_t;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_GAIN_WIDTH    = 6;
  localparam int DEF_GAIN_MIN      = 0;
  localparam int DEF_GAIN_MAX      = 63;
  localparam int DEF_GAIN_INIT     = 32;
  localparam int DEF_SETTLE_CYCLES = 64;
  localparam int DEF_COARSE_STEP   = 4;

endpackage

// File: rtl/agc_threshold_cmp.sv
// Combinational window classification of one power result.
// Ports: target/hyst/power in, res out (cmp_res_t).
module agc_threshold_cmp
  import agc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] target,
  input  logic [DATA_WIDTH-1:0] hyst,
  input  logic [DATA_WIDTH-1:0] power,
  output cmp_res_t              res
);

  localparam int W = DATA_WIDTH + 2;

  logic [W-1:0] tgt;
  logic [W-1:0] hys;
  logic [W-1:0] pwr;
  logic [W-1:0] upper;
  logic [W-1:0] lower;
  logic [W-1:0] lo_c;
  // upper<<2 kept two bits wider so the coarse limit never wraps
  logic [W+1:0] up_c;

  assign tgt   = {2'b00, target};
  assign hys   = {2'b00, hyst};
  assign pwr   = {2'b00, power};
  assign upper = tgt + hys;
  assign lower = (tgt > hys) ? (tgt - hys) : '0;
  assign up_c  = {upper, 2'b00};
  assign lo_c  = lower >> 2;

  always_comb begin
    res = IN_WIN;
    if ({2'b00, pwr} > up_c) begin
      res = HIGH_COARSE;
    end else if (pwr > upper) begin
      res = HIGH;
    end else if (pwr < lo_c) begin
      res = LOW_COARSE;
    end else if (pwr < lower) begin
      res = LOW;
    end
  end

endmodule

// File: rtl/agc_power_controller.sv
// Closed-loop AGC: steps gain from average-power results, then settles.
// Ports: enable/freeze/target/hyst/avg_power in; gain_code/flags out.
module agc_power_controller
  import agc_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int GAIN_WIDTH    = DEF_GAIN_WIDTH,
  parameter int GAIN_MIN      = DEF_GAIN_MIN,
  parameter int GAIN_MAX      = DEF_GAIN_MAX,
  parameter int GAIN_INIT     = DEF_GAIN_INIT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int COARSE_STEP   = DEF_COARSE_STEP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  freeze,
  input  logic [DATA_WIDTH-1:0] target_power,
  input  logic [DATA_WIDTH-1:0] hysteresis,
  input  logic [DATA_WIDTH-1:0] avg_power_in,
  input  logic                  avg_power_valid,
  output logic [GAIN_WIDTH-1:0] gain_code,
  output logic                  gain_update,
  output logic                  locked,
  output logic                  at_min,
  output logic                  at_max
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int GW = GAIN_WIDTH + 2;

  agc_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GAIN_WIDTH-1:0] gain_q, gain_d;
  logic upd_q, upd_d;
  logic lock_q, lock_d;

  cmp_res_t res;
  logic [GW-1:0] g_ext;
  logic [GW-1:0] dn_step;
  logic [GW-1:0] up_step;
  logic [GW-1:0] g_dn;
  logic [GW-1:0] g_up;
  logic [GW-1:0] g_new;

  agc_threshold_cmp #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp (
    .target (target_power),
    .hyst   (hysteresis),
    .power  (avg_power_in),
    .res    (res)
  );

  // Saturating candidates, computed wide so a step never wraps
  assign g_ext   = {2'b00, gain_q};
  assign dn_step = (res == HIGH_COARSE) ? GW'(COARSE_STEP) : GW'(1);
  assign up_step = (res == LOW_COARSE) ? GW'(COARSE_STEP) : GW'(1);
  assign g_dn = (g_ext < GW'(GAIN_MIN) + dn_step)
              ? GW'(GAIN_MIN) : g_ext - dn_step;
  assign g_up = (g_ext + up_step > GW'(GAIN_MAX))
              ? GW'(GAIN_MAX) : g_ext + up_step;
  assign g_new = (res == HIGH_COARSE || res == HIGH) ? g_dn : g_up;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gain_q  <= GAIN_WIDTH'(GAIN_INIT);
      upd_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gain_q  <= gain_d;
      upd_q   <= upd_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gain_d  = gain_q;
    upd_d   = 1'b0;
    lock_d  = lock_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      lock_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = MEASURE;
        MEASURE: begin
          if (avg_power_valid && !freeze) begin
            if (res == IN_WIN) begin
              lock_d = 1'b1;
            end else begin
              lock_d = 1'b0;
              // already pinned at the limit: no change, keep measuring
              if (g_new != g_ext) begin
                gain_d  = g_new[GAIN_WIDTH-1:0];
                upd_d   = 1'b1;
                cnt_d   = '0;
                state_d = SETTLE;
              end
            end
          end
        end
        SETTLE: begin
          if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = DISCARD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DISCARD: begin
          if (avg_power_valid) state_d = MEASURE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign gain_code   = gain_q;
  assign gain_update = upd_q;
  assign locked      = lock_q;
  assign at_min      = (gain_q == GAIN_WIDTH'(GAIN_MIN));
  assign at_max      = (gain_q == GAIN_WIDTH'(GAIN_MAX));

endmodule

// File: tb/tb_agc_power_controller.sv
// Directed bench for agc_power_controller with default parameters.
// Target 0x1000, hyst 0x100: window 0xF00..0x1100, coarse 0x3C0/0x4400.
module tb_agc_power_controller;
  import agc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        freeze;
  logic [31:0] target_power;
  logic [31:0] hysteresis;
  logic [31:0] avg_power_in;
  logic        avg_power_valid;
  logic [5:0]  gain_code;
  logic        gain_update;
  logic        locked;
  logic        at_min;
  logic        at_max;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  agc_power_controller dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .freeze          (freeze),
    .target_power    (target_power),
    .hysteresis      (hysteresis),
    .avg_power_in    (avg_power_in),
    .avg_power_valid (avg_power_valid),
    .gain_code       (gain_code),
    .gain_update     (gain_update),
    .locked          (locked),
    .at_min          (at_min),
    .at_max          (at_max)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [31:0] p);
    avg_power_in    = p;
    avg_power_valid = 1'b1;
    step();
    avg_power_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int g, input logic u,
                         input logic l, input agc_state_t s);
    chk({tag, "_gain"}, 32'(gain_code), 32'(g));
    chk({tag, "_upd"}, 32'(gain_update), 32'(u));
    chk({tag, "_lock"}, 32'(locked), 32'(l));
    chk({tag, "_st"}, 32'(dut.state_q), 32'(s));
  endtask

  // called right after the change edge; ends back in MEASURE
  task automatic skip_settle(input string tag);
    repeat (64) step();
    chk({tag, "_disc"}, 32'(dut.state_q), 32'(DISCARD));
    strobe(32'h1200);
    chk({tag, "_meas"}, 32'(dut.state_q), 32'(MEASURE));
    chk({tag, "_nochg"}, 32'(gain_update), 32'd0);
  endtask

  initial begin
    int g;
    rst             = 1'b1;
    enable          = 1'b0;
    freeze          = 1'b0;
    target_power    = 32'h1000;
    hysteresis      = 32'h100;
    avg_power_in    = '0;
    avg_power_valid = 1'b0;
    step();
    step();
    chk_out("reset", 32, 1'b0, 1'b0, IDLE);
    chk("reset_min", 32'(at_min), 32'd0);
    chk("reset_max", 32'(at_max), 32'd0);

    rst    = 1'b0;
    enable = 1'b1;
    step();
    chk("enable_meas", 32'(dut.state_q), 32'(MEASURE));

    strobe(32'h1050);
    chk_out("inwin", 32, 1'b0, 1'b1, MEASURE);

    strobe(32'h1200);
    chk_out("fine_dn", 31, 1'b1, 1'b0, SETTLE);
    step();
    chk("pulse_single", 32'(gain_update), 32'd0);
    repeat (8) step();
    strobe(32'h1200);
    chk_out("settle_drop", 31, 1'b0, 1'b0, SETTLE);
    repeat (53) step();
    chk("settle_last", 32'(dut.state_q), 32'(SETTLE));
    step();
    chk("discard_ent", 32'(dut.state_q), 32'(DISCARD));
    strobe(32'h1200);
    chk_out("discard_drop", 31, 1'b0, 1'b0, MEASURE);
    strobe(32'h1050);
    chk_out("third_eval", 31, 1'b0, 1'b1, MEASURE);

    strobe(32'h8000);
    chk_out("coarse_dn", 27, 1'b1, 1'b0, SETTLE);
    skip_settle("s1");
    strobe(32'h200);
    chk_out("coarse_up", 31, 1'b1, 1'b0, SETTLE);
    skip_settle("s2");
    strobe(32'hE00);
    chk_out("fine_up", 32, 1'b1, 1'b0, SETTLE);
    skip_settle("s3");

    g = 32;
    for (int i = 0; i < 7; i++) begin
      g += 4;
      strobe(32'h200);
      chk("climb_c", 32'(gain_code), 32'(g));
      skip_settle("sc");
    end
    for (int i = 0; i < 2; i++) begin
      g += 1;
      strobe(32'hE00);
      chk("climb_f", 32'(gain_code), 32'(g));
      skip_settle("sf");
    end
    chk("at_62", 32'(gain_code), 32'd62);
    strobe(32'h200);
    chk_out("clip_max", 63, 1'b1, 1'b0, SETTLE);
    chk("at_max_hi", 32'(at_max), 32'd1);
    skip_settle("s4");
    strobe(32'h1050);
    chk("lock_at_max", 32'(locked), 32'd1);
    strobe(32'h200);
    chk_out("sat_hold", 63, 1'b0, 1'b0, MEASURE);
    chk("sat_max", 32'(at_max), 32'd1);

    freeze = 1'b1;
    strobe(32'h8000);
    chk_out("frozen", 63, 1'b0, 1'b0, MEASURE);
    freeze = 1'b0;
    strobe(32'h8000);
    chk_out("unfrozen", 59, 1'b1, 1'b0, SETTLE);
    chk("max_clr", 32'(at_max), 32'd0);

    repeat (5) step();
    rst = 1'b1;
    step();
    chk_out("mid_rst", 32, 1'b0, 1'b0, IDLE);
    chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
    chk("rst_max", 32'(at_max), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_meas", 32'(dut.state_q), 32'(MEASURE));

    strobe(32'h1050);
    chk("pre_dis_lock", 32'(locked), 32'd1);
    enable = 1'b0;
    strobe(32'h8000);
    chk_out("en_wins", 32, 1'b0, 1'b0, IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
